// File: rtl/dual_port_mem_responder.sv
// Memory-side responder for a CPU's instruction (read-only) and data (read/write) ports,
// each with a programmable latency and a one-cycle completion ack.

module dual_port_mem_responder_port #(
    parameter int LATENCY = 1
) (
    input  logic Clk,
    input  logic Reset,
    input  logic i_req,
    input  logic i_conflict,
    input  logic i_hold,
    output logic o_take,
    output logic o_done,
    output logic o_busy,
    output logic o_ack,
    output logic o_err
);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt, w_cnt_next;
    logic          r_err, w_err_next;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_err   <= w_err_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_err_next = 1'b0;
        o_take     = 1'b0;
        o_done     = 1'b0;
        case (r_state)
            S_BUSY: begin
                if (!i_hold) begin
                    w_next = S_IDLE;
                end else if (r_cnt == CW'(1)) begin
                    o_done     = 1'b1;
                    w_next     = S_RESP;
                    w_cnt_next = '0;
                end else begin
                    w_cnt_next = r_cnt - CW'(1);
                end
            end
            // IDLE and RESP both sample; RESP falls back to IDLE when nothing is pending
            default: begin
                w_next = S_IDLE;
                if (i_conflict) begin
                    w_err_next = 1'b1;
                end else if (i_req) begin
                    o_take = 1'b1;
                    if (LATENCY == 1) begin
                        o_done = 1'b1;
                        w_next = S_RESP;
                    end else begin
                        w_next     = S_BUSY;
                        w_cnt_next = CW'(LATENCY - 1);
                    end
                end
            end
        endcase
    end

    assign o_busy = (r_state == S_BUSY);
    assign o_ack  = (r_state == S_RESP);
    assign o_err  = r_err;
endmodule

module dual_port_mem_responder #(
    parameter int    WORD_SIZE = 16,
    parameter int    ADDR_BITS = 8,
    parameter int    LATENCY1  = 1,
    parameter int    LATENCY2  = 1,
    parameter string INIT_FILE = ""
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 readM1,
    input  logic [WORD_SIZE-1:0] address1,
    output logic [WORD_SIZE-1:0] data1,
    output logic                 ack1,
    input  logic                 readM2,
    input  logic                 writeM2,
    input  logic [WORD_SIZE-1:0] address2,
    inout  wire  [WORD_SIZE-1:0] data2,
    output logic                 ack2,
    output logic                 err2
);
    localparam int DEPTH = 1 << ADDR_BITS;

    logic [WORD_SIZE-1:0] r_mem [DEPTH];

    logic                 w_take1, w_done1, w_busy1, w_err1_unused;
    logic [ADDR_BITS-1:0] r_addr1, w_idx1;
    logic [WORD_SIZE-1:0] r_data1;

    logic                 w_take2, w_done2, w_busy2, w_hold2, w_wr2, w_commit2;
    logic                 r_op_wr2;
    logic [ADDR_BITS-1:0] r_addr2, w_idx2;
    logic [WORD_SIZE-1:0] r_wdata2, w_wdata2, r_rdbuf2;

    logic w_addr_unused;
    assign w_addr_unused = ^{address1[WORD_SIZE-1:ADDR_BITS], address2[WORD_SIZE-1:ADDR_BITS]};

    dual_port_mem_responder_port #(.LATENCY(LATENCY1)) u_port1 (
        .Clk       (Clk),
        .Reset     (Reset),
        .i_req     (readM1),
        .i_conflict(1'b0),
        .i_hold    (readM1),
        .o_take    (w_take1),
        .o_done    (w_done1),
        .o_busy    (w_busy1),
        .o_ack     (ack1),
        .o_err     (w_err1_unused)
    );

    // A held request must keep the same op level it was accepted with
    assign w_hold2 = r_op_wr2 ? writeM2 : readM2;

    dual_port_mem_responder_port #(.LATENCY(LATENCY2)) u_port2 (
        .Clk       (Clk),
        .Reset     (Reset),
        .i_req     (readM2 | writeM2),
        .i_conflict(readM2 & writeM2),
        .i_hold    (w_hold2),
        .o_take    (w_take2),
        .o_done    (w_done2),
        .o_busy    (w_busy2),
        .o_ack     (ack2),
        .o_err     (err2)
    );

    // At LATENCY=1 the op completes on the sampling edge, so use the live inputs
    assign w_idx1    = w_busy1 ? r_addr1  : address1[ADDR_BITS-1:0];
    assign w_idx2    = w_busy2 ? r_addr2  : address2[ADDR_BITS-1:0];
    assign w_wr2     = w_busy2 ? r_op_wr2 : writeM2;
    assign w_wdata2  = w_busy2 ? r_wdata2 : data2;
    assign w_commit2 = w_done2 & w_wr2 & ~Reset;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_addr1 <= '0;
            r_data1 <= '0;
        end else begin
            if (w_take1) r_addr1 <= address1[ADDR_BITS-1:0];
            if (w_done1) r_data1 <= r_mem[w_idx1];
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_addr2  <= '0;
            r_wdata2 <= '0;
            r_op_wr2 <= 1'b0;
            r_rdbuf2 <= '0;
        end else begin
            if (w_take2) begin
                r_addr2  <= address2[ADDR_BITS-1:0];
                r_wdata2 <= data2;
                r_op_wr2 <= writeM2;
            end
            if (w_done2 && !w_wr2) r_rdbuf2 <= r_mem[w_idx2];
        end
    end

    // Port-1 reads above sample the pre-write word when both complete on one address
    always_ff @(posedge Clk) begin
        if (w_commit2) r_mem[w_idx2] <= w_wdata2;
    end

    assign data1 = r_data1;
    assign data2 = (readM2 && !writeM2) ? r_rdbuf2 : 'z;
endmodule

// File: tb/tb_dual_port_mem_responder.sv
// Bench for dual_port_mem_responder: two instances (fast and slow latencies) driven in lockstep,
// checked against a transaction-level model, a vector table and directed corner sequences.

module tb_dual_port_mem_responder;
    logic        Clk = 1'b0;
    logic        rst;
    logic        rd1, rd2, wr2;
    logic [15:0] a1, a2, wd;

    logic [15:0] o_d1 [2];
    logic        o_ack1 [2];
    logic        o_ack2 [2];
    logic        o_err2 [2];
    wire  [15:0] d2_0, d2_1;

    int n_chk = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    assign d2_0 = wr2 ? wd : 'z;
    assign d2_1 = wr2 ? wd : 'z;

    dual_port_mem_responder #(.LATENCY1(1), .LATENCY2(1)) u_fast (
        .Clk(Clk), .Reset(rst), .readM1(rd1), .address1(a1), .data1(o_d1[0]), .ack1(o_ack1[0]),
        .readM2(rd2), .writeM2(wr2), .address2(a2), .data2(d2_0), .ack2(o_ack2[0]), .err2(o_err2[0])
    );

    dual_port_mem_responder #(.LATENCY1(4), .LATENCY2(3)) u_slow (
        .Clk(Clk), .Reset(rst), .readM1(rd1), .address1(a1), .data1(o_d1[1]), .ack1(o_ack1[1]),
        .readM2(rd2), .writeM2(wr2), .address2(a2), .data2(d2_1), .ack2(o_ack2[1]), .err2(o_err2[1])
    );

    // ---------------- reference model (transaction level) ----------------
    logic [15:0] m_mem [2][256];
    bit          m_b1 [2], m_b2 [2], m_wr [2];
    int          m_n1 [2], m_n2 [2];
    logic [7:0]  m_a1 [2], m_a2 [2];
    logic [15:0] m_wd [2], m_d1 [2], m_rb [2];
    bit          m_ack1 [2], m_ack2 [2], m_err [2];

    function automatic int lat1(int k); return (k == 0) ? 1 : 4; endfunction
    function automatic int lat2(int k); return (k == 0) ? 1 : 3; endfunction

    task automatic model_clear(input int k);
        m_b1[k] = 0; m_b2[k] = 0; m_d1[k] = '0; m_rb[k] = '0;
        m_ack1[k] = 0; m_ack2[k] = 0; m_err[k] = 0;
    endtask

    // An accepted request completes on its L-th edge, counting the accepting edge,
    // unless its request level drops first.
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                model_clear(k);
            end else begin : upd
                bit          do_wr;
                logic [7:0]  wa;
                logic [15:0] wv;
                do_wr = 0; wa = '0; wv = '0;
                m_ack1[k] = 0; m_ack2[k] = 0; m_err[k] = 0;
                if (!m_b1[k] && rd1) begin
                    m_b1[k] = 1; m_a1[k] = a1[7:0]; m_n1[k] = lat1(k);
                end else if (m_b1[k] && !rd1) begin
                    m_b1[k] = 0;
                end
                if (m_b1[k]) begin
                    m_n1[k] = m_n1[k] - 1;
                    if (m_n1[k] == 0) begin
                        m_d1[k] = m_mem[k][m_a1[k]]; m_ack1[k] = 1; m_b1[k] = 0;
                    end
                end
                if (!m_b2[k]) begin
                    if (rd2 && wr2) m_err[k] = 1;
                    else if (rd2 || wr2) begin
                        m_b2[k] = 1; m_wr[k] = wr2; m_a2[k] = a2[7:0]; m_wd[k] = wd; m_n2[k] = lat2(k);
                    end
                end else if (!(m_wr[k] ? wr2 : rd2)) begin
                    m_b2[k] = 0;
                end
                if (m_b2[k]) begin
                    m_n2[k] = m_n2[k] - 1;
                    if (m_n2[k] == 0) begin
                        if (m_wr[k]) begin do_wr = 1; wa = m_a2[k]; wv = m_wd[k]; end
                        else m_rb[k] = m_mem[k][m_a2[k]];
                        m_ack2[k] = 1; m_b2[k] = 0;
                    end
                end
                if (do_wr) m_mem[k][wa] = wv;
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        logic [15:0] d2v;
        @(posedge Clk);
        model_edge();
        #1;
        for (int k = 0; k < 2; k++) begin
            d2v = (k == 0) ? d2_0 : d2_1;
            chk($sformatf("ack1[%0d]", k), 16'(o_ack1[k]), 16'(m_ack1[k]));
            chk($sformatf("data1[%0d]", k), o_d1[k], m_d1[k]);
            chk($sformatf("ack2[%0d]", k), 16'(o_ack2[k]), 16'(m_ack2[k]));
            chk($sformatf("err2[%0d]", k), 16'(o_err2[k]), 16'(m_err[k]));
            if (rd2 && !wr2) chk($sformatf("data2[%0d]", k), d2v, m_rb[k]);
        end
    endtask

    task automatic idle_in();
        rd1 = 0; rd2 = 0; wr2 = 0; a1 = '0; a2 = '0; wd = '0;
    endtask

    function automatic logic [15:0] rand_addr();
        if ($urandom_range(0, 1) == 1) return 16'($urandom);
        return {6'($urandom_range(0, 63)), 2'b00, 8'($urandom_range(0, 7))};
    endfunction

    // ---------------- vector table (fast instance, LATENCY=1) ----------------
    typedef struct {
        logic        rd1;
        logic [15:0] a1;
        logic        rd2, wr2;
        logic [15:0] a2, wd;
        logic        ack1;
        logic [15:0] d1;
        logic        ack2, err2, chk_d2;
        logic [15:0] d2;
    } vec_t;

    function automatic vec_t mk(logic r1, logic [15:0] ad1, logic r2, logic w2, logic [15:0] ad2,
                                logic [15:0] wdat, logic k1, logic [15:0] e1, logic k2, logic e2,
                                logic c2, logic [15:0] ed2);
        vec_t v;
        v.rd1 = r1; v.a1 = ad1; v.rd2 = r2; v.wr2 = w2; v.a2 = ad2; v.wd = wdat;
        v.ack1 = k1; v.d1 = e1; v.ack2 = k2; v.err2 = e2; v.chk_d2 = c2; v.d2 = ed2;
        return v;
    endfunction

    vec_t tbl [12];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, n_chk=%0d", n_chk);
        $fatal(1);
    end

    initial begin
        logic [15:0] d1_keep;
        int          p2, r;

        //        rd1 a1        rd2 wr2 a2        wd        ack1 d1        ack2 err chk d2
        tbl[0]  = mk(0, 16'h0000, 0, 1, 16'h0005, 16'h1234, 0, 16'h0000, 1, 0, 0, 16'h0000);
        tbl[1]  = mk(0, 16'h0000, 0, 1, 16'h0009, 16'h0001, 0, 16'h0000, 1, 0, 0, 16'h0000);
        tbl[2]  = mk(1, 16'h0005, 0, 0, 16'h0000, 16'h0000, 1, 16'h1234, 0, 0, 0, 16'h0000);
        tbl[3]  = mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 16'h1234, 0, 0, 0, 16'h0000);
        tbl[4]  = mk(1, 16'h0009, 0, 1, 16'h0009, 16'hAAAA, 1, 16'h0001, 1, 0, 0, 16'h0000);
        tbl[5]  = mk(1, 16'h0009, 0, 0, 16'h0000, 16'h0000, 1, 16'hAAAA, 0, 0, 0, 16'h0000);
        tbl[6]  = mk(0, 16'h0000, 1, 0, 16'h0109, 16'h0000, 0, 16'hAAAA, 1, 0, 1, 16'hAAAA);
        tbl[7]  = mk(0, 16'h0000, 1, 1, 16'h0005, 16'hFFFF, 0, 16'hAAAA, 0, 1, 0, 16'h0000);
        tbl[8]  = mk(0, 16'h0000, 1, 0, 16'h0005, 16'h0000, 0, 16'hAAAA, 1, 0, 1, 16'h1234);
        tbl[9]  = mk(1, 16'hFF05, 1, 0, 16'h0009, 16'h0000, 1, 16'h1234, 1, 0, 1, 16'hAAAA);
        tbl[10] = mk(1, 16'h0005, 0, 0, 16'h0000, 16'h0000, 1, 16'h1234, 0, 0, 0, 16'h0000);
        tbl[11] = mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 16'h1234, 0, 0, 0, 16'h0000);

        // reset state
        idle_in();
        rst = 1;
        for (int k = 0; k < 2; k++) model_clear(k);
        step(); step();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_data1[%0d]", k), o_d1[k], 16'h0000);
            chk($sformatf("rst_ack1[%0d]", k), 16'(o_ack1[k]), 16'h0000);
            chk($sformatf("rst_ack2[%0d]", k), 16'(o_ack2[k]), 16'h0000);
            chk($sformatf("rst_err2[%0d]", k), 16'(o_err2[k]), 16'h0000);
        end
        rst = 0;

        // fill every word in both instances ({~a, a}); each write held three edges
        for (int a = 0; a < 256; a++) begin
            wr2 = 1; a2 = 16'(a); wd = {~8'(a), 8'(a)};
            step(); step(); step();
        end
        idle_in();

        for (int i = 0; i < 12; i++) begin
            rd1 = tbl[i].rd1; a1 = tbl[i].a1; rd2 = tbl[i].rd2; wr2 = tbl[i].wr2;
            a2 = tbl[i].a2; wd = tbl[i].wd;
            step();
            chk($sformatf("tbl%0d.ack1", i), 16'(o_ack1[0]), 16'(tbl[i].ack1));
            chk($sformatf("tbl%0d.data1", i), o_d1[0], tbl[i].d1);
            chk($sformatf("tbl%0d.ack2", i), 16'(o_ack2[0]), 16'(tbl[i].ack2));
            chk($sformatf("tbl%0d.err2", i), 16'(o_err2[0]), 16'(tbl[i].err2));
            if (tbl[i].chk_d2) chk($sformatf("tbl%0d.data2", i), d2_0, tbl[i].d2);
        end
        idle_in();
        step(); step();

        // slow port 2 (latency 3): write BEEF to 0x0107, inputs change while busy, read back via 7
        wr2 = 1; a2 = 16'h0107; wd = 16'hBEEF;
        step(); chk("lat3_wr_ack_t0", 16'(o_ack2[1]), 16'h0000);
        a2 = 16'h0033; wd = 16'h1111;
        step(); chk("lat3_wr_ack_t1", 16'(o_ack2[1]), 16'h0000);
        step(); chk("lat3_wr_ack_t2", 16'(o_ack2[1]), 16'h0001);
        wr2 = 0;
        step(); chk("lat3_wr_ack_after", 16'(o_ack2[1]), 16'h0000);
        rd2 = 1; a2 = 16'h0007;
        step(); step(); step();
        chk("lat3_rd_ack", 16'(o_ack2[1]), 16'h0001);
        chk("lat3_rd_wrap_data", d2_1, 16'hBEEF);
        idle_in();
        step();

        // slow port 1 (latency 4): full read, then an aborted read, then a new read
        rd1 = 1; a1 = 16'h0011;
        step(); step(); step(); step();
        chk("lat4_rd_ack", 16'(o_ack1[1]), 16'h0001);
        chk("lat4_rd_data", o_d1[1], 16'hEE11);
        a1 = 16'h0020;
        step(); step();
        rd1 = 0;
        step();
        chk("abort_ack1", 16'(o_ack1[1]), 16'h0000);
        chk("abort_data1", o_d1[1], 16'hEE11);
        rd1 = 1; a1 = 16'h0030;
        for (int i = 0; i < 3; i++) begin
            step(); chk($sformatf("after_abort_wait%0d", i), 16'(o_ack1[1]), 16'h0000);
        end
        step();
        chk("after_abort_ack1", 16'(o_ack1[1]), 16'h0001);
        chk("after_abort_data1", o_d1[1], 16'hCF30);
        idle_in();
        step();

        // reset during a slow write in flight
        wr2 = 1; a2 = 16'h0040; wd = 16'h5A5A;
        step(); step();
        #1 rst = 1;
        for (int k = 0; k < 2; k++) model_clear(k);
        #1;
        chk("midrst_ack2", 16'(o_ack2[1]), 16'h0000);
        chk("midrst_data1", o_d1[1], 16'h0000);
        step();
        chk("midrst_ack2_edge", 16'(o_ack2[1]), 16'h0000);
        rst = 0; wr2 = 0;
        step();
        rd2 = 1; a2 = 16'h0040;
        step(); step();
        chk("postrst_no_early_ack", 16'(o_ack2[1]), 16'h0000);
        step();
        chk("postrst_rd_ack", 16'(o_ack2[1]), 16'h0001);
        chk("postrst_word_kept", d2_1, 16'hBF40);
        idle_in();
        step();

        // randomized traffic with held requests, changing inputs, conflicts and rare resets
        p2 = 0;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 399) == 0);
            if (rd1) rd1 = ($urandom_range(0, 99) < 85);
            else     rd1 = ($urandom_range(0, 99) < 40);
            if (p2 == 0 || $urandom_range(0, 99) >= 85) begin
                r  = int'($urandom_range(0, 99));
                p2 = (r < 30) ? 1 : (r < 60) ? 2 : (r < 66) ? 3 : 0;
            end
            rd2 = (p2 == 1 || p2 == 3);
            wr2 = (p2 >= 2);
            a1  = rand_addr();
            a2  = rand_addr();
            wd  = 16'($urandom);
            step();
        end
        rst = 0;
        idle_in();
        step();

        // final read-back of a few words on the fast instance against the model
        for (int a = 0; a < 8; a++) begin
            rd1 = 1; a1 = 16'(a);
            step();
            d1_keep = m_mem[0][a];
            chk($sformatf("final_rd%0d", a), o_d1[0], d1_keep);
        end
        idle_in();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
